// File: rtl/step_ex_imm.sv
// Immediate-load execute step: field insert, shift-in, sign/zero-extend load into
// one register of the register file, over an open-drain step/register bus.
module step_ex_imm #(
  parameter  int IMM_W  = 4,
  parameter  int SLOT_W = 1,
  parameter  int RSEL_W = 2,
  localparam int WIDTH  = IMM_W << SLOT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena_,
  output logic              rdy_,
  output logic [RSEL_W-1:0] reg_sel,
  output logic [WIDTH-1:0]  reg_din,
  output logic              reg_we_,
  input  logic [WIDTH-1:0]  reg_dout,
  input  logic [RSEL_W-1:0] rd,
  input  logic [IMM_W-1:0]  immed,
  input  logic [SLOT_W-1:0] slot,
  input  logic [1:0]        mode
);

  localparam int NSLOT = 1 << SLOT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [RSEL_W-1:0]   rd_q, rd_d;
  logic [IMM_W-1:0]    immed_q, immed_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [1:0]          mode_q, mode_d;
  logic [WIDTH-1:0]    hold_q, hold_d;
  logic                sel_en_q, sel_en_d;
  logic                we_en_q, we_en_d;
  logic                rdy_en_q, rdy_en_d;
  logic                start;
  logic [WIDTH-1:0]    ins_w;
  logic [WIDTH-1:0]    result;

  // A new op may only be accepted from IDLE or DONE; requests in READ/WRITE are dropped.
  assign start = !ena_ && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    immed_d = immed_q;
    slot_d  = slot_q;
    mode_d  = mode_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          rd_d    = rd;
          immed_d = immed;
          slot_d  = slot;
          mode_d  = mode;
          state_d = mode[1] ? WRITE : READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        hold_d  = reg_dout;
        state_d = WRITE;
      end
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (rst) state_d = IDLE;
  end

  // Bus enables are decoded from the next state so every driver comes straight off a flop.
  always_comb begin
    sel_en_d = (state_d == READ) || (state_d == WRITE);
    we_en_d  = (state_d == WRITE);
    rdy_en_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      immed_q  <= '0;
      slot_q   <= '0;
      mode_q   <= '0;
      hold_q   <= '0;
      sel_en_q <= 1'b0;
      we_en_q  <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      immed_q  <= immed_d;
      slot_q   <= slot_d;
      mode_q   <= mode_d;
      hold_q   <= hold_d;
      sel_en_q <= sel_en_d;
      we_en_q  <= we_en_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  for (genvar s = 0; s < NSLOT; s++) begin : g_slot
    assign ins_w[s*IMM_W +: IMM_W] =
      (slot_q == SLOT_W'(s)) ? immed_q : hold_q[s*IMM_W +: IMM_W];
  end

  always_comb begin
    result = '0;
    case (mode_q)
      2'b00:   result = ins_w;
      2'b01:   result = {hold_q[WIDTH-IMM_W-1:0], immed_q};
      2'b10:   result = {{(WIDTH-IMM_W){immed_q[IMM_W-1]}}, immed_q};
      default: result = {{(WIDTH-IMM_W){1'b0}}, immed_q};
    endcase
  end

  assign rdy_    = rdy_en_q ? 1'b0   : 1'bz;
  assign reg_sel = sel_en_q ? rd_q   : {RSEL_W{1'bz}};
  assign reg_din = we_en_q  ? result : {WIDTH{1'bz}};
  assign reg_we_ = we_en_q  ? 1'b0   : 1'bz;

endmodule

// File: tb/tb_step_ex_imm.sv
// Directed bench for step_ex_imm. Each design is instantiated twice, once on pulled-up
// and once on pulled-down nets, so an undriven (Z) output shows up as up=1 / down=0.
module tb_step_ex_imm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena_n = 1'b1;
  logic [1:0]  rd = '0;
  logic [3:0]  immed = '0;
  logic        slot = '0;
  logic [1:0]  mode = '0;
  logic [7:0]  dout = '0;
  logic [1:0]  wslot = '0;
  logic [15:0] wdout = '0;

  int nchk = 0;
  int nerr = 0;
  int we_cnt = 0;
  int rdy_cnt = 0;

  always #5 clk = ~clk;

  wire       rdy_u, rdy_d, we_u, we_d;
  wire [1:0] sel_u, sel_d;
  wire [7:0] din_u, din_d;
  wire        wrdy_u, wrdy_d, wwe_u, wwe_d;
  wire [1:0]  wsel_u, wsel_d;
  wire [15:0] wdin_u, wdin_d;

  step_ex_imm u_up (.clk(clk), .rst(rst), .ena_(ena_n), .rdy_(rdy_u), .reg_sel(sel_u),
    .reg_din(din_u), .reg_we_(we_u), .reg_dout(dout), .rd(rd), .immed(immed),
    .slot(slot), .mode(mode));
  step_ex_imm u_dn (.clk(clk), .rst(rst), .ena_(ena_n), .rdy_(rdy_d), .reg_sel(sel_d),
    .reg_din(din_d), .reg_we_(we_d), .reg_dout(dout), .rd(rd), .immed(immed),
    .slot(slot), .mode(mode));
  step_ex_imm #(.SLOT_W(2)) u_wup (.clk(clk), .rst(rst), .ena_(ena_n), .rdy_(wrdy_u),
    .reg_sel(wsel_u), .reg_din(wdin_u), .reg_we_(wwe_u), .reg_dout(wdout), .rd(rd),
    .immed(immed), .slot(wslot), .mode(mode));
  step_ex_imm #(.SLOT_W(2)) u_wdn (.clk(clk), .rst(rst), .ena_(ena_n), .rdy_(wrdy_d),
    .reg_sel(wsel_d), .reg_din(wdin_d), .reg_we_(wwe_d), .reg_dout(wdout), .rd(rd),
    .immed(immed), .slot(wslot), .mode(mode));

  pullup   (rdy_u);
  pulldown (rdy_d);
  pullup   (we_u);
  pulldown (we_d);
  pullup   (wrdy_u);
  pulldown (wrdy_d);
  pullup   (wwe_u);
  pulldown (wwe_d);
  for (genvar i = 0; i < 2; i++) begin : g_psel
    pullup   (sel_u[i]);
    pulldown (sel_d[i]);
    pullup   (wsel_u[i]);
    pulldown (wsel_d[i]);
  end
  for (genvar i = 0; i < 8; i++) begin : g_pdin
    pullup   (din_u[i]);
    pulldown (din_d[i]);
  end
  for (genvar i = 0; i < 16; i++) begin : g_pwdin
    pullup   (wdin_u[i]);
    pulldown (wdin_d[i]);
  end

  // z = every bit floating; drv = every bit driven (value then read from the _d copy)
  wire rdy_z   = rdy_u & ~rdy_d;
  wire rdy_lo  = ~rdy_u & ~rdy_d;
  wire we_z    = we_u & ~we_d;
  wire we_lo   = ~we_u & ~we_d;
  wire sel_z   = &(sel_u & ~sel_d);
  wire sel_drv = (sel_u == sel_d);
  wire din_z   = &(din_u & ~din_d);
  wire din_drv = (din_u == din_d);
  wire all_z   = rdy_z & we_z & sel_z & din_z;
  wire wdin_drv = (wdin_u == wdin_d);
  wire wwe_lo   = ~wwe_u & ~wwe_d;

  always @(negedge clk) begin
    if (we_lo)  we_cnt++;
    if (rdy_lo) rdy_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena_n = 1'b1;
    tick(); tick();
    nchk++; if (all_z !== 1'b1) begin nerr++; $display("FAIL rst_allz: rdy=%b/%b sel=%h/%h din=%h/%h we=%b/%b want all Z", rdy_u, rdy_d, sel_u, sel_d, din_u, din_d, we_u, we_d); end
    rst = 1'b0;
    tick();
    nchk++; if (all_z !== 1'b1) begin nerr++; $display("FAIL rst_idle_allz: got not-all-Z, want all Z"); end
  endtask

  task automatic test_field_insert();
    rd = 2'd2; slot = 1'b1; immed = 4'hA; mode = 2'b00; dout = 8'h35; ena_n = 1'b0;
    tick();
    ena_n = 1'b1; rd = 2'd0; immed = 4'h0; slot = 1'b0; mode = 2'b11;
    nchk++; if ({sel_drv, sel_d} !== {1'b1, 2'd2}) begin nerr++; $display("FAIL fi_c1_sel: drv=%b sel=%h want drv 1 sel 2", sel_drv, sel_d); end
    nchk++; if ({we_z, din_z, rdy_z} !== 3'b111) begin nerr++; $display("FAIL fi_c1_z: we_z=%b din_z=%b rdy_z=%b want 111", we_z, din_z, rdy_z); end
    tick();
    dout = 8'h00;
    nchk++; if ({din_drv, din_d} !== {1'b1, 8'hA5}) begin nerr++; $display("FAIL fi_c2_din: drv=%b din=%h want A5", din_drv, din_d); end
    nchk++; if ({we_lo, sel_d, rdy_z} !== {1'b1, 2'd2, 1'b1}) begin nerr++; $display("FAIL fi_c2_ctl: we_lo=%b sel=%h rdy_z=%b want 1 2 1", we_lo, sel_d, rdy_z); end
    tick();
    nchk++; if ({rdy_lo, sel_z, din_z, we_z} !== 4'b1111) begin nerr++; $display("FAIL fi_c3: rdy_lo=%b sel_z=%b din_z=%b we_z=%b want 1111", rdy_lo, sel_z, din_z, we_z); end
    tick();
    nchk++; if (all_z !== 1'b1) begin nerr++; $display("FAIL fi_c4_allz: got %b want 1", all_z); end
  endtask

  task automatic test_shift();
    rd = 2'd1; immed = 4'hC; mode = 2'b01; dout = 8'h35; ena_n = 1'b0;
    tick(); ena_n = 1'b1;
    tick();
    nchk++; if ({din_drv, din_d, we_lo} !== {1'b1, 8'h5C, 1'b1}) begin nerr++; $display("FAIL shift_din: drv=%b din=%h we_lo=%b want 5C", din_drv, din_d, we_lo); end
    tick();
    nchk++; if (rdy_lo !== 1'b1) begin nerr++; $display("FAIL shift_rdy: rdy_lo=%b want 1", rdy_lo); end
    tick();
  endtask

  task automatic test_sext();
    rd = 2'd3; immed = 4'h9; mode = 2'b10; ena_n = 1'b0;
    nchk++; if (sel_z !== 1'b1) begin nerr++; $display("FAIL sext_pre_sel: sel_z=%b want 1", sel_z); end
    tick(); ena_n = 1'b1;
    nchk++; if ({din_drv, din_d, we_lo, sel_drv, sel_d} !== {1'b1, 8'hF9, 1'b1, 1'b1, 2'd3}) begin nerr++; $display("FAIL sext_c1: din=%h drv=%b we_lo=%b sel=%h want F9 1 1 3", din_d, din_drv, we_lo, sel_d); end
    tick();
    nchk++; if ({rdy_lo, we_z} !== 2'b11) begin nerr++; $display("FAIL sext_c2_rdy: rdy_lo=%b we_z=%b want 11", rdy_lo, we_z); end
    tick();
  endtask

  task automatic test_zext();
    rd = 2'd0; immed = 4'h9; mode = 2'b11; ena_n = 1'b0;
    tick(); ena_n = 1'b1;
    nchk++; if ({din_drv, din_d} !== {1'b1, 8'h09}) begin nerr++; $display("FAIL zext_din: drv=%b din=%h want 09", din_drv, din_d); end
    tick(); tick();
  endtask

  task automatic test_ena_held();
    int w0, r0;
    w0 = we_cnt; r0 = rdy_cnt;
    rd = 2'd1; immed = 4'h6; slot = 1'b0; mode = 2'b00; dout = 8'h77; ena_n = 1'b0;
    tick(); tick(); tick();
    ena_n = 1'b1;
    tick(); tick(); tick();
    nchk++; if (we_cnt - w0 !== 1) begin nerr++; $display("FAIL held_writes: got %0d want 1", we_cnt - w0); end
    nchk++; if (rdy_cnt - r0 !== 1) begin nerr++; $display("FAIL held_rdys: got %0d want 1", rdy_cnt - r0); end
  endtask

  task automatic test_back_to_back();
    rd = 2'd3; immed = 4'h5; mode = 2'b11; ena_n = 1'b0;
    tick(); ena_n = 1'b1;
    nchk++; if ({din_drv, din_d} !== {1'b1, 8'h05}) begin nerr++; $display("FAIL b2b_first_din: din=%h want 05", din_d); end
    tick();
    rd = 2'd1; immed = 4'h3; slot = 1'b0; mode = 2'b00; dout = 8'hF0; ena_n = 1'b0;
    nchk++; if (rdy_lo !== 1'b1) begin nerr++; $display("FAIL b2b_first_rdy: rdy_lo=%b want 1", rdy_lo); end
    tick(); ena_n = 1'b1;
    nchk++; if ({sel_drv, sel_d, rdy_z, we_z} !== {1'b1, 2'd1, 1'b1, 1'b1}) begin nerr++; $display("FAIL b2b_read: sel=%h drv=%b rdy_z=%b we_z=%b want 1 1 1 1", sel_d, sel_drv, rdy_z, we_z); end
    tick();
    nchk++; if ({din_drv, din_d} !== {1'b1, 8'hF3}) begin nerr++; $display("FAIL b2b_second_din: din=%h want F3", din_d); end
    tick();
    nchk++; if (rdy_lo !== 1'b1) begin nerr++; $display("FAIL b2b_second_rdy: rdy_lo=%b want 1", rdy_lo); end
    tick();
  endtask

  task automatic test_reset_mid();
    int w0, r0;
    w0 = we_cnt; r0 = rdy_cnt;
    rd = 2'd2; immed = 4'h1; slot = 1'b0; mode = 2'b00; dout = 8'h44; ena_n = 1'b0;
    tick(); ena_n = 1'b1; rst = 1'b1;
    tick(); rst = 1'b0;
    nchk++; if (all_z !== 1'b1) begin nerr++; $display("FAIL rmid_allz: got %b want 1", all_z); end
    tick(); tick(); tick();
    nchk++; if ({we_cnt - w0, rdy_cnt - r0} !== {32'd0, 32'd0}) begin nerr++; $display("FAIL rmid_counts: writes=%0d rdys=%0d want 0 0", we_cnt - w0, rdy_cnt - r0); end
    immed = 4'h2; mode = 2'b11; ena_n = 1'b0;
    tick(); ena_n = 1'b1;
    nchk++; if ({din_drv, din_d} !== {1'b1, 8'h02}) begin nerr++; $display("FAIL rmid_after_din: din=%h want 02", din_d); end
    tick();
    nchk++; if (rdy_lo !== 1'b1) begin nerr++; $display("FAIL rmid_after_rdy: rdy_lo=%b want 1", rdy_lo); end
    tick();
  endtask

  task automatic test_reset_priority();
    int w0, r0;
    w0 = we_cnt; r0 = rdy_cnt;
    mode = 2'b11; immed = 4'hF; rst = 1'b1; ena_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nchk++; if (all_z !== 1'b1) begin nerr++; $display("FAIL rprio_allz_%0d: got %b want 1", i, all_z); end
    end
    rst = 1'b0; ena_n = 1'b1;
    tick(); tick();
    nchk++; if ({all_z, we_cnt - w0, rdy_cnt - r0} !== {1'b1, 32'd0, 32'd0}) begin nerr++; $display("FAIL rprio_nostart: allz=%b writes=%0d rdys=%0d want 1 0 0", all_z, we_cnt - w0, rdy_cnt - r0); end
  endtask

  task automatic test_wide();
    rd = 2'd1; wslot = 2'd3; immed = 4'h7; mode = 2'b00; wdout = 16'h1234; ena_n = 1'b0;
    tick(); ena_n = 1'b1;
    tick();
    nchk++; if ({wdin_drv, wdin_d, wwe_lo} !== {1'b1, 16'h7234, 1'b1}) begin nerr++; $display("FAIL wide_ins: drv=%b din=%h we_lo=%b want 7234", wdin_drv, wdin_d, wwe_lo); end
    tick(); tick();
    immed = 4'h8; mode = 2'b10; ena_n = 1'b0;
    tick(); ena_n = 1'b1;
    nchk++; if ({wdin_drv, wdin_d} !== {1'b1, 16'hFFF8}) begin nerr++; $display("FAIL wide_sext: drv=%b din=%h want FFF8", wdin_drv, wdin_d); end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_field_insert();
    test_shift();
    test_sext();
    test_zext();
    test_ena_held();
    test_back_to_back();
    test_reset_mid();
    test_reset_priority();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
